// File: rtl/rom_pkg.sv
// rom_pkg: shared types for the ROM stream sequencer
package rom_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rom_stream_state_t;
endpackage

// File: rtl/rom_stream_if.sv
// rom_stream_if: valid/ready word stream from the ROM sequencer to its consumer
interface rom_stream_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  modport master(output out_data, out_valid, out_last, input out_ready);
  modport slave(input out_data, out_valid, out_last, output out_ready);
endinterface

// File: rtl/rom_stream.sv
// rom_stream: walks a combinational-read ROM and streams consecutive words, optionally looping
module rom_stream
  import rom_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int ADDRW = $clog2(DEPTH),
  localparam int LENW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDRW-1:0] start_addr,
  input  logic [LENW-1:0]  len,
  input  logic             loop,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  rom_stream_if.master     st
);
  rom_stream_state_t state, state_nxt;
  logic [LENW-1:0] remain, base_len;
  logic [ADDRW-1:0] base_addr;
  logic loop_q, xfer, accept, load, last_load, rewind, finish, done_nxt;
  assign busy = state != IDLE;
  // next state plus the load/transfer strobes shared with the datapath
  always_comb begin
    xfer = st.out_valid & st.out_ready;
    accept = state == IDLE & start & len != '0;
    load = state == RUN & !stop & remain != '0 & (!st.out_valid | st.out_ready);
    last_load = load & remain == LENW'(1);
    rewind = last_load & loop_q;
    finish = state == DRAIN & (!st.out_valid | xfer);
    done_nxt = (state == IDLE & start & len == '0) | finish;
    state_nxt = accept ? RUN
              : (state == RUN & (stop | (last_load & !loop_q))) ? DRAIN
              : finish ? IDLE
              : state;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // address walk, word capture and output register; a rewind reloads the pass with no bubble
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rom_addr <= '0;
      remain <= '0;
      base_addr <= '0;
      base_len <= '0;
      loop_q <= 1'b0;
      done <= 1'b0;
      st.out_data <= '0;
      st.out_valid <= 1'b0;
      st.out_last <= 1'b0;
    end else begin
      done <= done_nxt;
      if (accept) begin
        rom_addr <= start_addr;
        remain <= len;
        base_addr <= start_addr;
        base_len <= len;
        loop_q <= loop;
      end else if (load) begin
        st.out_data <= rom_data;
        st.out_valid <= 1'b1;
        st.out_last <= last_load;
        rom_addr <= rewind ? base_addr : rom_addr == ADDRW'(DEPTH - 1) ? '0 : rom_addr + ADDRW'(1);
        remain <= rewind ? base_len : remain - LENW'(1);
      end else if (xfer) st.out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_rom_stream.sv
// tb_rom_stream: directed checks of rom_stream against a 16x8 ROM holding 8'h10+i
module tb_rom_stream;
  localparam int W = 8;
  localparam int D = 16;
  localparam int AW = 4;
  localparam int LW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic loop = 1'b0;
  logic stop = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [LW-1:0] len = '0;
  logic busy, done;
  logic [AW-1:0] rom_addr;
  logic [W-1:0] rom_data;
  logic [W-1:0] rom [D];
  int n_cmp = 0;
  int n_err = 0;
  rom_stream_if #(.WIDTH(W)) s();
  rom_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
    .loop(loop), .stop(stop), .busy(busy), .done(done), .rom_addr(rom_addr),
    .rom_data(rom_data), .st(s)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < D; i++) rom[i] = 8'h10 + 8'(i);
  assign rom_data = rom[rom_addr];
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic v, input logic [7:0] d, input logic l, input logic dn, input logic b);
    @(negedge clk);
    chk({tag, " valid"}, 32'(s.out_valid), 32'(v));
    if (v) begin
      chk({tag, " data"}, 32'(s.out_data), 32'(d));
      chk({tag, " last"}, 32'(s.out_last), 32'(l));
    end
    chk({tag, " done"}, 32'(done), 32'(dn));
    chk({tag, " busy"}, 32'(busy), 32'(b));
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [AW-1:0] sa, input logic [LW-1:0] ln, input logic lp);
    start = 1'b1;
    start_addr = sa;
    len = ln;
    loop = lp;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  initial begin
    logic [7:0] wexp [4];
    wexp = '{8'h1E, 8'h1F, 8'h10, 8'h11};
    s.out_ready = 1'b1;
    #3;
    chk("rst valid", 32'(s.out_valid), 0);
    chk("rst addr", 32'(rom_addr), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    launch(3, 4, 0);
    chk("basic addr", 32'(rom_addr), 3);
    cyc("basic c1", 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc("basic beat", 1, 8'(8'h13 + i), i == 3, 0, 1);
    cyc("basic done", 0, 0, 0, 1, 0);
    cyc("basic idle", 0, 0, 0, 0, 0);
    launch(14, 4, 0);
    cyc("wrap c1", 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) chk("wrap addr15", 32'(rom_addr), 15);
      if (i == 1) chk("wrap addr0", 32'(rom_addr), 0);
      cyc("wrap beat", 1, wexp[i], i == 3, 0, 1);
    end
    cyc("wrap done", 0, 0, 0, 1, 0);
    launch(1, 3, 0);
    cyc("bp c1", 0, 0, 0, 0, 1);
    cyc("bp c2", 1, 8'h11, 0, 0, 1);
    s.out_ready = 1'b0;
    cyc("bp c3", 1, 8'h12, 0, 0, 1);
    cyc("bp c4", 1, 8'h12, 0, 0, 1);
    s.out_ready = 1'b1;
    cyc("bp c5", 1, 8'h12, 0, 0, 1);
    cyc("bp c6", 1, 8'h13, 1, 0, 1);
    cyc("bp done", 0, 0, 0, 1, 0);
    launch(0, 2, 1);
    cyc("loop c1", 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc("loop beat", 1, 8'(8'h10 + i % 2), i % 2 == 1, 0, 1);
    stop = 1'b1;
    cyc("loop stop", 1, 8'h11, 1, 0, 1);
    stop = 1'b0;
    cyc("loop drain", 0, 0, 0, 0, 1);
    cyc("loop done", 0, 0, 0, 1, 0);
    cyc("loop quiet", 0, 0, 0, 0, 0);
    cyc("loop quiet2", 0, 0, 0, 0, 0);
    loop = 1'b0;
    launch(0, 0, 0);
    cyc("len0 c1", 0, 0, 0, 1, 0);
    cyc("len0 c2", 0, 0, 0, 0, 0);
    launch(5, 16, 0);
    cyc("full c1", 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc("full beat", 1, 8'(8'h10 + (5 + i) % 16), i == 15, 0, 1);
    cyc("full done", 0, 0, 0, 1, 0);
    launch(0, 8, 0);
    cyc("mid c1", 0, 0, 0, 0, 1);
    cyc("mid c2", 1, 8'h10, 0, 0, 1);
    cyc("mid c3", 1, 8'h11, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 32'(s.out_valid), 0);
    chk("mid rst data", 32'(s.out_data), 0);
    chk("mid rst last", 32'(s.out_last), 0);
    chk("mid rst addr", 32'(rom_addr), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst done", 32'(done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("post rst idle", 0, 0, 0, 0, 0);
    launch(7, 2, 0);
    cyc("post c1", 0, 0, 0, 0, 1);
    cyc("post c2", 1, 8'h17, 0, 0, 1);
    cyc("post c3", 1, 8'h18, 1, 0, 1);
    cyc("post done", 0, 0, 0, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rom_stream.md
# rom_stream

Address sequencer and stream source for a ROM with combinational read. Drives the ROM address, captures each returned word into a registered output, and presents it as a valid/ready stream to downstream logic such as palette loaders and sprite or bitmap fetchers. One start request streams a run of consecutive words, optionally looping, at one word per cycle when not back-pressured.

## Interface
- WIDTH, 8, ROM word width in bits
- DEPTH, 256, ROM depth in words; need not be a power of two
- ADDRW, $clog2(DEPTH), localparam, ROM address width
- LENW, $clog2(DEPTH+1), localparam, length width; allows len = DEPTH

- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- start_addr  in  ADDRW  first address, sampled with start; must be < DEPTH
- len  in  LENW  words per pass, sampled with start; 0..DEPTH
- loop  in  1  repeat the pass until stop; sampled with start
- stop  in  1  abort fetching; honoured in RUN
- busy  out  1  high in RUN and DRAIN
- done  out  1  single-cycle pulse when a run completes
- rom_addr  out  ADDRW  address to the ROM, registered
- rom_data  in  WIDTH  combinational ROM read data for rom_addr
- out_data  out  WIDTH  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from the consumer
- out_last  out  1  marks the final word of each pass; qualified by out_valid

## Operation
- FSM states: IDLE, RUN, DRAIN.
- Reset: state IDLE; rom_addr, out_data, out_last, out_valid, busy and done all 0; the remaining-word count is 0.
- IDLE, start=1, len>0: rom_addr <= start_addr, remain <= len, latch start_addr, len and loop, then go to RUN.
- IDLE, start=1, len=0: done pulses on the next cycle, produces no output, and stays in IDLE.
- RUN load condition: remain>0 and (!out_valid or out_ready). When it is true:
  - out_data <= rom_data; out_valid <= 1; out_last <= (remain==1).
  - rom_addr <= (rom_addr==DEPTH-1) ? 0 : rom_addr+1; remain <= remain-1.
- Handshake: a beat transfers when out_valid and out_ready are both high. If out_ready is low, out_data and out_last hold. If no load occurs on a transfer, out_valid <= 0.
- End of pass (load with remain==1):
  - If loop is latched and stop is low: rom_addr <= latched start_addr, remain <= latched len, stay in RUN with no bubble.
  - Otherwise go to DRAIN.
- stop in RUN: no further load occurs from that cycle on, and the FSM goes to DRAIN. The beat already in the output register still completes.
- DRAIN: wait until out_valid is 0, or until the holding beat transfers in this cycle. Then done pulses for one cycle and the FSM returns to IDLE.
- start in RUN or DRAIN is ignored. stop in IDLE or DRAIN is ignored.
- Reset asserted mid-run: every output returns immediately to its reset value. The partial stream is dropped and done does not pulse.

## Timing
- The cycle with start high in IDLE is cycle 0. rom_addr is valid from cycle 1, and out_valid first rises at cycle 2.
- With out_ready held high, a pass of N words occupies cycles 2..N+1, one word per cycle. Loop passes follow back to back.
- For a non-loop run with out_ready high, the last beat transfers in cycle N+1 and done is high in cycle N+2. busy is low from cycle N+2.
- Back-pressure adds exactly one cycle per cycle that out_ready is low while out_valid is high. No word is dropped or duplicated.
- The ROM path is rom_addr register to ROM to out_data register, which is one combinational ROM access per cycle.

## Structure
- Shared package rom_pkg holds the FSM state enum, rom_stream_state_t (IDLE, RUN, DRAIN).
- This block has no sub-module; the ROM is external. The bench pairs rom_stream with the team's asynchronous ROM, with rom_addr wired to the ROM address and the ROM data wired to rom_data.

## Test plan
- Use DEPTH=16 and WIDTH=8, with the ROM initialised so that word[i] = 8'h10+i, for all scenarios.
- Basic run: start_addr=3, len=4, out_ready=1. Required: out_data 13,14,15,16 in cycles 2..5, out_last only with 16, done in cycle 6.
- Wrap-around: start_addr=14, len=4. Required: 1E,1F,10,11, then rom_addr returns to 0 after 15.
- Back-pressure: len=3, with out_ready low in cycles 3–4. Required: 12 held stable in cycles 3–4, the full sequence intact, done delayed 2 cycles.
- Loop and stop: start_addr=0, len=2, loop=1, with stop pulsed after the fifth transfer. Required: 10,11,10,11,10 then 11 (the beat in flight completes, out_last set on it), then done and nothing further.
- Edge lengths and reset:
  - len=0: done pulses in cycle 1 and out_valid never rises.
  - len=16 from address 5: all 16 words in order, ending at 14.
  - rst_n low during RUN: outputs clear at once, and a following start works normally.
